// File: rtl/sp_bus_arb_pkg.sv
// Shared definitions for the two-master console-bus arbiter.
package sp_bus_arb_pkg;

    // Arbiter ownership states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    // Read data returned to a master whose strobe was terminated by timeout.
    localparam logic [0:7] TIMEOUT_DATA = 8'hff;

endpackage

// File: rtl/sp_bus_arb_if.sv
// Bus bundle for sp_bus_arb: two Wishbone masters and one shared 8-bit slave.
// The "slave" modport is the arbiter's view (it is the slave of both masters);
// the "master" modport is the environment driving requests and slave replies.
interface sp_bus_arb_if;

    logic [0:23] m0_adr_i, m1_adr_i;
    logic [0:7]  m0_dat_i, m1_dat_i;
    logic [0:7]  m0_dat_o, m1_dat_o;
    logic        m0_we_i,  m1_we_i;
    logic        m0_stb_i, m1_stb_i;
    logic        m0_cyc_i, m1_cyc_i;
    logic [0:0]  m0_sel_i, m1_sel_i;
    logic        m0_ack_o, m1_ack_o;

    logic [0:23] s_adr_o;
    logic [0:7]  s_dat_o;
    logic        s_we_o;
    logic [0:0]  s_sel_o;
    logic        s_stb_o;
    logic        s_cyc_o;
    logic [0:7]  s_dat_i;
    logic        s_ack_i;

    modport slave (
        input  m0_adr_i, m0_dat_i, m0_we_i, m0_stb_i, m0_cyc_i, m0_sel_i,
        input  m1_adr_i, m1_dat_i, m1_we_i, m1_stb_i, m1_cyc_i, m1_sel_i,
        output m0_dat_o, m0_ack_o, m1_dat_o, m1_ack_o,
        output s_adr_o, s_dat_o, s_we_o, s_sel_o, s_stb_o, s_cyc_o,
        input  s_dat_i, s_ack_i
    );

    modport master (
        output m0_adr_i, m0_dat_i, m0_we_i, m0_stb_i, m0_cyc_i, m0_sel_i,
        output m1_adr_i, m1_dat_i, m1_we_i, m1_stb_i, m1_cyc_i, m1_sel_i,
        input  m0_dat_o, m0_ack_o, m1_dat_o, m1_ack_o,
        input  s_adr_o, s_dat_o, s_we_o, s_sel_o, s_stb_o, s_cyc_o,
        output s_dat_i, s_ack_i
    );

endinterface

// File: rtl/sp_bus_arb.sv
// Two-master round-robin arbiter for the 8-bit console bus. Ownership is held
// for the whole cyc window so multi-byte sequences are never split, and a
// stalled strobe is terminated after TIMEOUT cycles with a fake 0xff read.
module sp_bus_arb
    import sp_bus_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset,
    sp_bus_arb_if.slave   bus,
    output logic          timeout_o
);

    localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

    arb_state_e  state, state_nxt;
    logic        last_grant, last_grant_nxt;
    logic [7:0]  stall_cnt;

    // Signals of whichever master currently owns the bus (all 0 in IDLE).
    logic [0:23] own_adr;
    logic [0:7]  own_dat;
    logic        own_we;
    logic [0:0]  own_sel;
    logic        own_stb;
    logic        own_cyc;
    logic        to_fire;

    // Next-state: round-robin grant from IDLE, hold while owner keeps cyc.
    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        case (state)
            IDLE: begin
                if (bus.m0_cyc_i && (!bus.m1_cyc_i || last_grant)) begin
                    state_nxt      = OWN0;
                    last_grant_nxt = 1'b0;
                end else if (bus.m1_cyc_i) begin
                    state_nxt      = OWN1;
                    last_grant_nxt = 1'b1;
                end
            end
            OWN0:    if (!bus.m0_cyc_i) state_nxt = IDLE;
            OWN1:    if (!bus.m1_cyc_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Select the owning master's request signals.
    always_comb begin
        own_adr = '0;
        own_dat = '0;
        own_we  = 1'b0;
        own_sel = '0;
        own_stb = 1'b0;
        own_cyc = 1'b0;
        case (state)
            OWN0: begin
                own_adr = bus.m0_adr_i;
                own_dat = bus.m0_dat_i;
                own_we  = bus.m0_we_i;
                own_sel = bus.m0_sel_i;
                own_stb = bus.m0_stb_i;
                own_cyc = bus.m0_cyc_i;
            end
            OWN1: begin
                own_adr = bus.m1_adr_i;
                own_dat = bus.m1_dat_i;
                own_we  = bus.m1_we_i;
                own_sel = bus.m1_sel_i;
                own_stb = bus.m1_stb_i;
                own_cyc = bus.m1_cyc_i;
            end
            default: ;
        endcase
    end

    // A real ack in the limit cycle wins over the timeout.
    assign to_fire = (state != IDLE) && own_stb && (stall_cnt == TO_LIM) && !bus.s_ack_i;

    // Drive the slave side and route ack/data back to the owner only.
    always_comb begin
        bus.s_adr_o  = own_adr;
        bus.s_dat_o  = own_dat;
        bus.s_we_o   = own_we;
        bus.s_sel_o  = own_sel;
        bus.s_stb_o  = own_stb && !to_fire;
        bus.s_cyc_o  = own_cyc;
        bus.m0_ack_o = 1'b0;
        bus.m0_dat_o = '0;
        bus.m1_ack_o = 1'b0;
        bus.m1_dat_o = '0;
        if (state == OWN0) begin
            bus.m0_ack_o = bus.s_ack_i || to_fire;
            bus.m0_dat_o = to_fire ? TIMEOUT_DATA : bus.s_dat_i;
        end else if (state == OWN1) begin
            bus.m1_ack_o = bus.s_ack_i || to_fire;
            bus.m1_dat_o = to_fire ? TIMEOUT_DATA : bus.s_dat_i;
        end
    end

    // State, grant history, stall counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            stall_cnt  <= '0;
            timeout_o  <= 1'b0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            // Counter is held at 0 in IDLE, so every fresh grant starts clean.
            if (state == IDLE || bus.s_ack_i || to_fire)
                stall_cnt <= '0;
            else if (bus.s_stb_o)
                stall_cnt <= stall_cnt + 8'd1;
            if (to_fire)
                timeout_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sp_bus_arb.sv
// Self-checking bench for sp_bus_arb: directed scenarios then random traffic,
// every cycle compared against a behavioural ownership/timeout model.
module tb_sp_bus_arb;

    localparam int TO = 4;

    logic clk = 1'b0;
    logic reset;
    logic timeout_o;

    always #5 clk = ~clk;

    sp_bus_arb_if bus();

    sp_bus_arb #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .timeout_o (timeout_o)
    );

    // Stimulus state, per master.
    logic [0:23] adr [2];
    logic [0:7]  wd  [2];
    logic        we  [2];
    logic [0:0]  sel [2];
    logic        stb [2];
    logic        cyc [2];
    logic [0:7]  sdat;
    logic        sack;
    logic        rst;

    // Reference model: owner (-1 = nobody), last granted, stall count, flag.
    int   mo, ml, mc;
    logic mt;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        for (int m = 0; m < 2; m++) begin
            adr[m] = '0; wd[m] = '0; we[m] = 1'b0; sel[m] = '0;
            stb[m] = 1'b0; cyc[m] = 1'b0;
        end
        sdat = '0;
        sack = 1'b0;
    endtask

    // One clock: apply inputs, check outputs mid-cycle, advance the model.
    task automatic step();
        logic [63:0] es;
        logic [8:0]  e0, e1;
        logic        fire, st;
        reset        = rst;
        bus.m0_adr_i = adr[0]; bus.m1_adr_i = adr[1];
        bus.m0_dat_i = wd[0];  bus.m1_dat_i = wd[1];
        bus.m0_we_i  = we[0];  bus.m1_we_i  = we[1];
        bus.m0_sel_i = sel[0]; bus.m1_sel_i = sel[1];
        bus.m0_stb_i = stb[0]; bus.m1_stb_i = stb[1];
        bus.m0_cyc_i = cyc[0]; bus.m1_cyc_i = cyc[1];
        bus.s_dat_i  = sdat;
        bus.s_ack_i  = sack;
        @(negedge clk);
        es = '0; e0 = '0; e1 = '0; fire = 1'b0;
        if (mo >= 0) begin
            st   = stb[mo];
            fire = st && (mc == TO) && !sack;
            es   = {28'd0, adr[mo], wd[mo], we[mo], sel[mo], st && !fire, cyc[mo]};
            if (mo == 0) e0 = {sack || fire, fire ? 8'hff : sdat};
            else         e1 = {sack || fire, fire ? 8'hff : sdat};
        end
        chk("slave_side", {28'd0, bus.s_adr_o, bus.s_dat_o, bus.s_we_o, bus.s_sel_o,
                           bus.s_stb_o, bus.s_cyc_o}, es);
        chk("m0_ack_dat", 64'({bus.m0_ack_o, bus.m0_dat_o}), 64'(e0));
        chk("m1_ack_dat", 64'({bus.m1_ack_o, bus.m1_dat_o}), 64'(e1));
        chk("timeout_o", 64'(timeout_o), 64'(mt));
        @(posedge clk);
        if (rst) begin
            mo = -1; ml = 1; mc = 0; mt = 1'b0;
        end else if (mo < 0) begin
            mc = 0;
            if (cyc[0] && cyc[1]) mo = 1 - ml;
            else if (cyc[0])      mo = 0;
            else if (cyc[1])      mo = 1;
            if (mo >= 0) ml = mo;
        end else begin
            if (fire) mt = 1'b1;
            if (sack || fire)  mc = 0;
            else if (stb[mo])  mc = mc + 1;
            if (!cyc[mo]) mo = -1;
        end
        #1;
    endtask

    initial begin
        mo = -1; ml = 1; mc = 0; mt = 1'b0;
        clr();

        // Reset with garbage on the inputs.
        rst = 1'b1;
        cyc[0] = 1'b1; stb[0] = 1'b1; sack = 1'b1; sdat = 8'h3c;
        step(); step();
        chk("reset_s_cyc", 64'(bus.s_cyc_o), 64'(0));
        chk("reset_timeout", 64'(timeout_o), 64'(0));
        rst = 1'b0; clr();
        step();

        // m0 alone reads 0x123456; slave acks after 2 stalled cycles.
        cyc[0] = 1'b1; stb[0] = 1'b1; adr[0] = 24'h123456; sel[0] = 1'b1;
        step();
        step(); step();
        sack = 1'b1; sdat = 8'h5a;
        step();
        sack = 1'b0; cyc[0] = 1'b0; stb[0] = 1'b0;
        step(); step();

        // Tie from reset: m0 first, one dead cycle, then m1.
        rst = 1'b1; step(); rst = 1'b0;
        cyc[0] = 1'b1; stb[0] = 1'b1; adr[0] = 24'h000a0a;
        cyc[1] = 1'b1; stb[1] = 1'b1; adr[1] = 24'h0b0b00;
        sack = 1'b1; sdat = 8'h11;
        step();
        chk("tie_m0_first", 64'(bus.s_adr_o), 64'(24'h000a0a));
        step();
        cyc[0] = 1'b0; stb[0] = 1'b0;
        step();
        chk("dead_cycle", 64'(bus.s_cyc_o), 64'(0));
        step();
        chk("then_m1", 64'(bus.s_adr_o), 64'(24'h0b0b00));
        sack = 1'b0;
        step();
        clr(); step(); step();

        // m0 holds cyc across 4 acked strobes while m1 waits.
        cyc[0] = 1'b1; stb[0] = 1'b1; adr[0] = 24'h400000; we[0] = 1'b1; wd[0] = 8'hc3;
        step();
        cyc[1] = 1'b1; stb[1] = 1'b1; adr[1] = 24'h500000;
        for (int k = 0; k < 4; k++) begin
            sack = 1'b1; adr[0] = 24'h400000 + 24'(k);
            step();
        end
        chk("m0_still_owns", 64'(bus.s_adr_o), 64'(adr[0]));
        sack = 1'b0; cyc[0] = 1'b0; stb[0] = 1'b0;
        step(); step();
        chk("m1_after_m0", 64'(bus.s_adr_o), 64'(24'h500000));
        clr(); step(); step();

        // Slave never acks: timeout on the 5th stalled cycle.
        cyc[1] = 1'b1; stb[1] = 1'b1; adr[1] = 24'h00beef;
        step();
        for (int k = 0; k < 7; k++) step();
        chk("timeout_set", 64'(timeout_o), 64'(1));
        clr(); step(); step();
        chk("timeout_sticky", 64'(timeout_o), 64'(1));

        // Real ack exactly at the limit wins.
        rst = 1'b1; step(); rst = 1'b0;
        cyc[0] = 1'b1; stb[0] = 1'b1; adr[0] = 24'h00cafe;
        step();
        for (int k = 0; k < TO; k++) step();
        sack = 1'b1; sdat = 8'h77;
        step();
        chk("ack_beats_timeout", 64'(timeout_o), 64'(0));
        clr(); step();

        // Strobe without cyc is ignored.
        stb[1] = 1'b1; sack = 1'b1;
        step(); step();
        clr(); step();

        // Reset in the middle of an m1 transfer, then a tie goes to m0.
        cyc[1] = 1'b1; stb[1] = 1'b1; adr[1] = 24'h0f0f0f;
        step(); step();
        rst = 1'b1; step(); rst = 1'b0;
        chk("reset_mid_cyc", 64'(bus.s_cyc_o), 64'(0));
        chk("reset_mid_ack", 64'(bus.m1_ack_o), 64'(0));
        cyc[0] = 1'b1; stb[0] = 1'b1; adr[0] = 24'h0a0a0a;
        step();
        chk("tie_after_reset", 64'(bus.s_adr_o), 64'(24'h0a0a0a));
        clr(); step(); step();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            for (int m = 0; m < 2; m++) begin
                if ($urandom_range(0, 5) == 0) cyc[m] = ~cyc[m];
                stb[m] = ($urandom_range(0, 3) != 0);
                adr[m] = 24'($urandom);
                wd[m]  = 8'($urandom);
                we[m]  = 1'($urandom);
                sel[m] = 1'($urandom);
            end
            sack = ($urandom_range(0, 3) == 0);
            sdat = 8'($urandom);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sp_bus_arb.md
SP_BUS_ARB -- requirements
Module: sp_bus_arb

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning stalled-strobe cycles before forced termination (legal 1..255).
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports mN_adr_i (N=0,1)  input  [0:23]  master N byte address.
REQ-005 SHALL have ports mN_dat_i  input  [0:7]  master N write data.
REQ-006 SHALL have ports mN_dat_o  output  [0:7]  master N read data.
REQ-007 SHALL have ports mN_we_i, mN_stb_i, mN_cyc_i  input  1 each  master N Wishbone controls.
REQ-008 SHALL have ports mN_sel_i  input  [0:0]  master N byte select.
REQ-009 SHALL have ports mN_ack_o  output  1  master N acknowledge.
REQ-010 SHALL have ports s_adr_o [0:23], s_dat_o [0:7], s_we_o, s_sel_o [0:0], s_stb_o, s_cyc_o  outputs  shared 8-bit console-bus slave side.
REQ-011 SHALL have ports s_dat_i  input  [0:7]  and  s_ack_i  input  1  slave read data and acknowledge.
REQ-012 SHALL have port timeout_o  output  1  sticky bus-timeout flag.

Function
REQ-013 SHALL implement a state machine with states IDLE, OWN0, OWN1; state and grant registered.
REQ-014 In IDLE, a single asserted mN_cyc_i SHALL move to OWNN next cycle; both asserted SHALL grant the master not granted last (round-robin); after reset, last-granted = 1 (m0 wins first tie).
REQ-015 OWNN SHALL persist while mN_cyc_i is high, regardless of stb, so a 4-byte sequenced word transfer is never split.
REQ-016 When the owner drops cyc, the block SHALL return to IDLE next cycle (one dead cycle between owners).
REQ-017 In OWNN, s_adr_o/s_dat_o/s_we_o/s_sel_o/s_stb_o/s_cyc_o SHALL combinationally follow master N; in IDLE s_stb_o=s_cyc_o=0 and other slave outputs 0.
REQ-018 mN_ack_o SHALL equal s_ack_i only when N owns the bus; non-owner ack and dat_o SHALL be 0; owner dat_o = s_dat_i.
REQ-019 An 8-bit stall counter SHALL clear on grant and on every s_ack_i, and increment each cycle s_stb_o=1 and s_ack_i=0.
REQ-020 When the counter reaches TIMEOUT with no s_ack_i that cycle, the block SHALL assert the owner's ack for exactly one cycle with dat_o = 8'hff, force s_stb_o=0 that cycle, clear the counter, and set timeout_o.
REQ-021 If s_ack_i arrives in the cycle the counter would reach TIMEOUT, the real ack SHALL win; no timeout.
REQ-022 timeout_o SHALL clear only on reset.
REQ-023 A master raising stb without cyc SHALL never be granted or acknowledged.

Reset
REQ-024 reset SHALL force IDLE, counter 0, last-granted 1, timeout_o 0, all ack/stb/cyc outputs 0, taking precedence mid-transfer; state after reset deassert is IDLE.

Structure
REQ-025 State encodings and the 8'hff timeout read value SHALL live in the shared sp package.
REQ-026 Implementation SHALL be a single module with no sub-modules; the stall counter is inline.

Verification
REQ-027 m0 alone reads 0x123456, slave acks after 2 cycles with 0x5a -> grant next cycle, m0_ack_o 1 cycle, m0_dat_o=0x5a, m1_ack_o 0 throughout.
REQ-028 m0 and m1 raise cyc same cycle from reset -> OWN0 first; after m0 drops cyc, one IDLE cycle, then OWN1.
REQ-029 m0 holds cyc across 4 acked byte strobes while m1 requests -> m1 not granted until m0 cyc falls.
REQ-030 TIMEOUT=4, slave never acks -> owner ack on 5th stalled cycle with dat 0xff, s_stb_o low that cycle, timeout_o stays 1.
REQ-031 s_ack_i coincides with counter reaching TIMEOUT -> real data delivered, timeout_o stays 0.
REQ-032 reset asserted mid-transfer of OWN1 -> next cycle all outputs 0, state IDLE; next tie grants m0.
